// File: rtl/pak_crc_sequencer.sv
// Bit-serial controller-pak CRC-8 (poly 0x85, init 0x00, 8 zero augmentation bits)
// over fixed-length blocks of BLOCK_LEN bytes, one bit step per clock.

`timescale 1ns/1ps

module pak_crc_sequencer #(
  parameter int unsigned BLOCK_LEN = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [7:0] crc_out,
  output logic       crc_valid,
  output logic       busy
);

  localparam logic [7:0] Poly     = 8'h85;
  localparam logic [5:0] LastByte = 6'(BLOCK_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StFlush,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] crc_out_q, crc_out_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [5:0] byte_cnt_q, byte_cnt_d;

  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic din);
    crc_step = {crc[6:0], din} ^ (crc[7] ? Poly : 8'h00);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      crc_q      <= 8'h00;
      shift_q    <= 8'h00;
      crc_out_q  <= 8'h00;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      shift_q    <= shift_d;
      crc_out_q  <= crc_out_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    shift_d    = shift_q;
    crc_out_d  = crc_out_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;

    // start wins in every state, including a same-cycle byte_valid in IDLE.
    if (start) begin
      state_d    = StLoad;
      crc_d      = 8'h00;
      shift_d    = 8'h00;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 6'd0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StLoad: begin
          if (byte_valid) begin
            shift_d   = byte_in;
            bit_cnt_d = 3'd7;
            state_d   = StShift;
          end
        end
        StShift: begin
          crc_d   = crc_step(crc_q, shift_q[7]);
          shift_d = {shift_q[6:0], 1'b0};
          if (bit_cnt_q == 3'd0) begin
            if (byte_cnt_q == LastByte) begin
              bit_cnt_d = 3'd7;
              state_d   = StFlush;
            end else begin
              byte_cnt_d = byte_cnt_q + 6'd1;
              state_d    = StLoad;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        StFlush: begin
          crc_d = crc_step(crc_q, 1'b0);
          if (bit_cnt_q == 3'd0) begin
            // Result is published on entry so it is visible during the DONE pulse.
            crc_out_d = crc_step(crc_q, 1'b0);
            state_d   = StDone;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  assign byte_ready = (state_q == StLoad);
  assign crc_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign crc_out    = crc_out_q;

endmodule

// File: tb/tb_pak_crc_sequencer.sv
// Directed bench: one instance with BLOCK_LEN=1 for per-byte vectors and corner cases,
// one with BLOCK_LEN=32 for full-block latency, gaps and aborts.

`timescale 1ns/1ps

module tb_pak_crc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       a_start, a_valid, a_ready, a_crc_valid, a_busy;
  logic [7:0] a_byte, a_crc;
  logic       b_start, b_valid, b_ready, b_crc_valid, b_busy;
  logic [7:0] b_byte, b_crc;

  pak_crc_sequencer #(.BLOCK_LEN(1)) u_dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (a_start),
    .byte_in    (a_byte),
    .byte_valid (a_valid),
    .byte_ready (a_ready),
    .crc_out    (a_crc),
    .crc_valid  (a_crc_valid),
    .busy       (a_busy)
  );

  pak_crc_sequencer #(.BLOCK_LEN(32)) u_dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (b_start),
    .byte_in    (b_byte),
    .byte_valid (b_valid),
    .byte_ready (b_ready),
    .crc_out    (b_crc),
    .crc_valid  (b_crc_valid),
    .busy       (b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int a_pulses = 0;
  int b_pulses = 0;

  always @(negedge clk) begin
    if (a_crc_valid) a_pulses++;
    if (b_crc_valid) b_pulses++;
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] crc;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] blk  [32];
  int         gap  [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference CRC straight from the algorithm definition, over blk[0..n-1].
  function automatic logic [7:0] model_crc(input int n);
    logic [7:0] c;
    logic [7:0] m;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i <= n; i++) begin
      m = (i < n) ? blk[i] : 8'h00;
      for (int j = 7; j >= 0; j--) begin
        fb = c[7];
        c  = {c[6:0], m[j]};
        if (fb) c = c ^ 8'h85;
      end
    end
    return c;
  endfunction

  // Single-byte block on DUT a; lat is the cycle index (1 = first cycle after the
  // handshake edge) at which crc_valid is seen.
  task automatic a_block(input logic [7:0] d, input logic [7:0] prev_crc,
                         output logic [7:0] crc, output int lat);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("a_crc_held_after_start", a_crc, prev_crc);
    check("a_ready_in_load", a_ready, 1'b1);
    a_valid = 1'b1;
    a_byte  = d;
    @(negedge clk);
    a_valid = 1'b0;
    a_byte  = 8'($urandom);
    lat = 1;
    while (!a_crc_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    crc = a_crc;
  endtask

  // Full block from blk/gap on DUT b; byte_valid is held high with junk while not in LOAD.
  task automatic b_block(output logic [7:0] crc, output int total, output int lat);
    int k, h;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    k = 1;
    for (int i = 0; i < 32; i++) begin
      while (!b_ready && k < 2000) begin
        b_valid = 1'b1;
        b_byte  = 8'($urandom);
        @(negedge clk);
        k++;
      end
      b_valid = 1'b0;
      for (int g = 0; g < gap[i]; g++) begin
        b_byte = 8'($urandom);
        @(negedge clk);
        k++;
      end
      b_valid = 1'b1;
      b_byte  = blk[i];
      @(negedge clk);
      k++;
      b_valid = 1'b0;
    end
    h = k;
    while (!b_crc_valid && k < 2000) begin
      @(negedge clk);
      k++;
    end
    crc   = b_crc;
    total = k;
    lat   = k - h + 1;
  endtask

  initial begin
    logic [7:0] crc, prev;
    int lat, total, p0, k, ready_err, gsum;

    vecs[0] = '{data: 8'h01, crc: 8'h85};
    vecs[1] = '{data: 8'h80, crc: 8'h89};
    vecs[2] = '{data: 8'h00, crc: 8'h00};
    vecs[3] = '{data: 8'h02, crc: 8'h8F};
    vecs[4] = '{data: 8'h40, crc: 8'h86};
    vecs[5] = '{data: 8'hFF, crc: 8'h8D};

    a_start = 1'b0; a_valid = 1'b0; a_byte = 8'h00;
    b_start = 1'b0; b_valid = 1'b0; b_byte = 8'h00;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    check("rst_a_crc_out", a_crc, 8'h00);
    check("rst_a_crc_valid", a_crc_valid, 1'b0);
    check("rst_a_byte_ready", a_ready, 1'b0);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_b_crc_out", b_crc, 8'h00);
    check("rst_b_crc_valid", b_crc_valid, 1'b0);
    check("rst_b_byte_ready", b_ready, 1'b0);
    check("rst_b_busy", b_busy, 1'b0);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // Single-byte vectors.
    prev = 8'h00;
    for (int i = 0; i < 6; i++) begin
      p0 = a_pulses;
      a_block(vecs[i].data, prev, crc, lat);
      check("a_vec_crc", crc, vecs[i].crc);
      check("a_vec_latency", lat, 17);
      idle(3);
      check("a_vec_pulses", a_pulses - p0, 1);
      prev = vecs[i].crc;
    end

    // start and byte_valid together in IDLE: byte must not be taken.
    a_start = 1'b1; a_valid = 1'b1; a_byte = 8'hFF;
    #1;
    check("a_idle_ready_low", a_ready, 1'b0);
    @(negedge clk);
    a_start = 1'b0; a_valid = 1'b0;
    check("a_same_cycle_busy", a_busy, 1'b1);
    check("a_same_cycle_still_load", a_ready, 1'b1);
    a_valid = 1'b1; a_byte = 8'h40;
    @(negedge clk);
    a_valid = 1'b0;
    lat = 1;
    while (!a_crc_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("a_same_cycle_crc", a_crc, 8'h86);
    idle(3);

    // Abort in SHIFT, then a clean block: only one pulse.
    p0 = a_pulses;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_valid = 1'b1; a_byte = 8'h80;
    @(negedge clk);
    a_valid = 1'b0;
    idle(4);
    a_block(8'h01, 8'h86, crc, lat);
    check("a_abort_crc", crc, 8'h85);
    check("a_abort_latency", lat, 17);
    idle(3);
    check("a_abort_pulses", a_pulses - p0, 1);

    // Zero block on DUT b with byte_valid held high throughout.
    p0 = b_pulses;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0; b_valid = 1'b1; b_byte = 8'h00;
    k = 1;
    ready_err = 0;
    while (!b_crc_valid && k < 400) begin
      if (b_ready !== (k <= 280 && (k - 1) % 9 == 0)) ready_err++;
      @(negedge clk);
      k++;
    end
    b_valid = 1'b0;
    check("b_zero_crc", b_crc, 8'h00);
    check("b_zero_valid_cycle", k, 297);
    check("b_zero_ready_pattern_errs", ready_err, 0);
    idle(3);
    check("b_zero_pulses", b_pulses - p0, 1);

    // Random blocks with random LOAD gaps.
    for (int r = 0; r < 2; r++) begin
      gsum = 0;
      for (int i = 0; i < 32; i++) begin
        blk[i] = 8'($urandom);
        gap[i] = int'($urandom_range(0, 3));
        gsum  += gap[i];
      end
      p0 = b_pulses;
      b_block(crc, total, lat);
      check("b_rand_crc", crc, model_crc(32));
      check("b_rand_total_cycles", total, 297 + gsum);
      check("b_rand_latency", lat, 17);
      idle(3);
      check("b_rand_pulses", b_pulses - p0, 1);
    end

    // Abort after 10 bytes, then a full block.
    p0 = b_pulses;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      while (!b_ready && k < 200) begin
        @(negedge clk);
        k++;
      end
      b_valid = 1'b1; b_byte = 8'($urandom);
      @(negedge clk);
      b_valid = 1'b0;
    end
    idle(3);
    for (int i = 0; i < 32; i++) begin
      blk[i] = 8'(i * 7 + 1);
      gap[i] = 0;
    end
    b_block(crc, total, lat);
    check("b_abort_crc", crc, model_crc(32));
    check("b_abort_total_cycles", total, 297);
    idle(3);
    check("b_abort_pulses", b_pulses - p0, 1);

    // Reset in FLUSH on DUT a: outputs clear without waiting for a clock edge.
    p0 = a_pulses;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_valid = 1'b1; a_byte = 8'h80;
    @(negedge clk);
    a_valid = 1'b0;
    idle(11);
    #2 reset_n = 1'b0;
    #1;
    check("rstf_crc_out", a_crc, 8'h00);
    check("rstf_busy", a_busy, 1'b0);
    check("rstf_crc_valid", a_crc_valid, 1'b0);
    check("rstf_byte_ready", a_ready, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(30);
    check("rstf_no_pulse", a_pulses - p0, 0);
    check("rstf_crc_stays_zero", a_crc, 8'h00);
    check("rstf_idle_after", a_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
